// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer with valid/ready push and stall/bubble pop.
// Optional FDQ_HALT_HOLD_EN: stop accepting records after a non-AOK status has been queued, until a flush.
`ifndef STAT_AOK
  `define STAT_BUBBLE 3'd0
  `define STAT_AOK    3'd1
  `define STAT_HLT    3'd2
  `define STAT_ADR    3'd3
  `define STAT_INS    3'd4
  `define INOP        4'h1
  `define RNONE       4'hF
`endif

module fetch_decode_queue #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         f_valid_i,
  output logic                         f_ready_o,
  input  logic [2:0]                   f_stat_i,
  input  logic [PC_W-1:0]              f_pc_i,
  input  logic [PC_W-1:0]              f_valC_i,
  input  logic [PC_W-1:0]              f_valP_i,
  input  logic [3:0]                   f_icode_i,
  input  logic [3:0]                   f_ifun_i,
  input  logic [3:0]                   f_rA_i,
  input  logic [3:0]                   f_rB_i,
  input  logic                         D_stall_i,
  input  logic                         D_bubble_i,
  output logic [2:0]                   D_stat_o,
  output logic [PC_W-1:0]              D_pc_o,
  output logic [PC_W-1:0]              D_valC_o,
  output logic [PC_W-1:0]              D_valP_o,
  output logic [3:0]                   D_icode_o,
  output logic [3:0]                   D_ifun_o,
  output logic [3:0]                   D_rA_o,
  output logic [3:0]                   D_rB_o,
  output logic                         D_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]      stat;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] valc;
    logic [PC_W-1:0] valp;
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [3:0]      ra;
    logic [3:0]      rb;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          f_rec;
  rec_t          head;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          halted;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign f_rec     = '{stat: f_stat_i, pc: f_pc_i, valc: f_valC_i, valp: f_valP_i,
                       icode: f_icode_i, ifun: f_ifun_i, ra: f_rA_i, rb: f_rB_i};
  assign f_ready_o = (count < CW'(DEPTH)) && !halted;
  assign push      = f_valid_i && f_ready_o;
  assign pop       = !D_stall_i && (count != '0);
  assign count_o   = count;
  assign head      = mem[rp];

`ifdef FDQ_HALT_HOLD_EN
  // Sticky until flush: a bubble discards any same-cycle push, so it always wins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      halted <= 1'b0;
    end else if (D_bubble_i) begin
      halted <= 1'b0;
    end else if (push && (f_stat_i != `STAT_AOK)) begin
      halted <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (D_bubble_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= ptr_inc(wp);
      if (pop)  rp <= ptr_inc(rp);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push && !D_bubble_i) mem[wp] <= f_rec;
  end

  always_comb begin
    D_stat_o  = `STAT_BUBBLE;
    D_pc_o    = '0;
    D_valC_o  = '0;
    D_valP_o  = '0;
    D_icode_o = `INOP;
    D_ifun_o  = '0;
    D_rA_o    = `RNONE;
    D_rB_o    = `RNONE;
    D_valid_o = 1'b0;
    if (count != '0) begin
      D_stat_o  = head.stat;
      D_pc_o    = head.pc;
      D_valC_o  = head.valc;
      D_valP_o  = head.valp;
      D_icode_o = head.icode;
      D_ifun_o  = head.ifun;
      D_rA_o    = head.ra;
      D_rB_o    = head.rb;
      D_valid_o = 1'b1;
    end
    if (!rst_n_i) D_stat_o = 3'd0;
  end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: expected records queued at push, checked at the head every cycle.
`ifndef STAT_AOK
  `define STAT_BUBBLE 3'd0
  `define STAT_AOK    3'd1
  `define STAT_HLT    3'd2
  `define STAT_ADR    3'd3
  `define STAT_INS    3'd4
  `define INOP        4'h1
  `define RNONE       4'hF
`endif

module tb_fetch_decode_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 64;

  typedef struct packed {
    logic [2:0]  stat;
    logic [63:0] pc;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_valid = 1'b0;
  logic        D_stall = 1'b0;
  logic        D_bubble = 1'b0;
  rec_t        cur = '0;
  logic        f_ready;
  logic [2:0]  D_stat;
  logic [63:0] D_pc, D_valC, D_valP;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic        D_valid;
  logic [$clog2(DEPTH+1)-1:0] count;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  bit   m_halted = 1'b0;

  fetch_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .f_valid_i(f_valid), .f_ready_o(f_ready),
    .f_stat_i(cur.stat), .f_pc_i(cur.pc), .f_valC_i(cur.valc), .f_valP_i(cur.valp),
    .f_icode_i(cur.icode), .f_ifun_i(cur.ifun), .f_rA_i(cur.ra), .f_rB_i(cur.rb),
    .D_stall_i(D_stall), .D_bubble_i(D_bubble),
    .D_stat_o(D_stat), .D_pc_o(D_pc), .D_valC_o(D_valC), .D_valP_o(D_valP),
    .D_icode_o(D_icode), .D_ifun_o(D_ifun), .D_rA_o(D_rA), .D_rB_o(D_rB),
    .D_valid_o(D_valid), .count_o(count)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (exp_q.size() < DEPTH) && !m_halted;
  endfunction

  // Reference model: a plain FIFO of records, updated at each clock edge from the sampled inputs.
  initial forever begin
    bit do_push, do_pop;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      m_halted = 1'b0;
    end else if (D_bubble) begin
      exp_q.delete();
      m_halted = 1'b0;
    end else begin
      do_push = f_valid && model_ready();
      do_pop  = !D_stall && (exp_q.size() != 0);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(cur);
`ifdef FDQ_HALT_HOLD_EN
        if (cur.stat != `STAT_AOK) m_halted = 1'b1;
`endif
      end
    end
  end

  // Monitor: mid-cycle comparison of everything the DUT presents against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("count", 64'(count), 64'(exp_q.size()));
      check("f_ready", 64'(f_ready), 64'(model_ready()));
      check("D_valid", 64'(D_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("head_pc", D_pc, exp_q[0].pc);
        check("head_valC", D_valC, exp_q[0].valc);
        check("head_valP", D_valP, exp_q[0].valp);
        check("head_stat", 64'(D_stat), 64'(exp_q[0].stat));
        check("head_regs", {48'd0, D_icode, D_ifun, D_rA, D_rB},
              {48'd0, exp_q[0].icode, exp_q[0].ifun, exp_q[0].ra, exp_q[0].rb});
      end else begin
        check("bub_stat", 64'(D_stat), 64'(`STAT_BUBBLE));
        check("bub_fields", {48'd0, D_icode, D_ifun, D_rA, D_rB},
              {48'd0, `INOP, 4'h0, `RNONE, `RNONE});
        check("bub_pc", D_pc | D_valC | D_valP, 64'd0);
      end
    end
  end

  task automatic drive(input bit v, input bit st, input bit bub,
                       input logic [2:0] stat, input logic [63:0] pc);
    @(posedge clk);
    #2;
    f_valid    = v;
    D_stall    = st;
    D_bubble   = bub;
    cur.stat   = stat;
    cur.pc     = pc;
    cur.valc   = {$urandom(), $urandom()};
    cur.valp   = pc + 64'($urandom_range(1, 10));
    cur.icode  = 4'($urandom_range(0, 11));
    cur.ifun   = 4'($urandom());
    cur.ra     = 4'($urandom());
    cur.rb     = 4'($urandom());
  endtask

  function automatic logic [63:0] rpc();
    return {$urandom(), $urandom()};
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_f_ready"}, 64'(f_ready), 64'd1);
    check({tag, "_D_valid"}, 64'(D_valid), 64'd0);
    check({tag, "_D_stat"}, 64'(D_stat), 64'd0);
    check({tag, "_icode"}, 64'(D_icode), 64'(`INOP));
    check({tag, "_regs"}, {56'd0, D_rA, D_rB}, {56'd0, `RNONE, `RNONE});
    check({tag, "_pc"}, D_pc, 64'd0);
  endtask

  initial begin
    logic [2:0] rs;
    #7;
    reset_checks("rst");
    #6 rst_n = 1'b1;

    // In-order flow of three records, then bubble.
    drive(1, 0, 0, `STAT_AOK, 64'h10);
    drive(1, 0, 0, `STAT_AOK, 64'h1A);
    drive(1, 0, 0, `STAT_AOK, 64'h24);
    drive(0, 0, 0, `STAT_AOK, 64'h0);
    drive(0, 0, 0, `STAT_AOK, 64'h0);

    // Fill under stall, then sustained push+pop with wrap-around, then drain.
    for (int i = 0; i < 6; i++)  drive(1, 1, 0, `STAT_AOK, rpc());
    for (int i = 0; i < 12; i++) drive(1, 0, 0, `STAT_AOK, rpc());
    for (int i = 0; i < 6; i++)  drive(0, 0, 0, `STAT_AOK, rpc());

    // Flush with count = 3 while stalled and offering a record.
    for (int i = 0; i < 3; i++) drive(1, 1, 0, `STAT_AOK, rpc());
    drive(1, 1, 1, `STAT_AOK, 64'hDEAD);
    drive(0, 0, 0, `STAT_AOK, 64'h0);
    drive(0, 0, 0, `STAT_AOK, 64'h0);

    // AOK then HLT record, keep offering, then flush.
    drive(1, 0, 0, `STAT_AOK, 64'h100);
    drive(1, 0, 0, `STAT_HLT, 64'h104);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, `STAT_AOK, rpc());
    drive(1, 0, 1, `STAT_ADR, rpc());
    for (int i = 0; i < 3; i++) drive(1, 0, 0, `STAT_AOK, rpc());
    drive(0, 0, 0, `STAT_AOK, 64'h0);
    drive(0, 0, 0, `STAT_AOK, 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rs = `STAT_AOK;
      if ($urandom_range(0, 15) == 0) rs = 3'($urandom_range(2, 4));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 11) == 0, rs, rpc());
    end

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) drive(1, 1, 0, `STAT_AOK, rpc());
    drive(0, 0, 0, `STAT_AOK, rpc());
    @(posedge clk);
    #4 rst_n = 1'b0;
    #3;
    reset_checks("async_rst");
    #5 rst_n = 1'b1;
    for (int i = 0; i < 40; i++)
      drive($urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0, 1'b0, `STAT_AOK, rpc());
    drive(0, 0, 0, `STAT_AOK, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Parametrised successor of the F→D pipeline register. It sits between fetch and decode and holds up to DEPTH fetched instruction records in a circular buffer with a valid/ready handshake on the fetch side. On the decode side it keeps the stall/bubble semantics the pipeline control unit already drives. When the queue is empty, decode sees a bubble (NOP) record; `D_bubble_i` flushes every queued entry.

## Interface
Parameters:
- `DEPTH`, 2: number of entries; any integer ≥ 2, need not be a power of two.
- `PC_W`, 64: width of pc, valC and valP fields.

Ports:
- `clk_i`, in, 1: single clock; all state updates on the rising edge.
- `rst_n_i`, in, 1: reset, asynchronous and active-low.
- `f_valid_i`, in, 1: fetch offers a record this cycle.
- `f_ready_o`, out, 1: queue accepts a record this cycle.
- `f_stat_i`, in, 3: fetch status (`` `STAT_* `` codes).
- `f_pc_i`, `f_valC_i`, `f_valP_i`, in, `PC_W`: pc, constant word, next pc.
- `f_icode_i`, `f_ifun_i`, `f_rA_i`, `f_rB_i`, in, 4 each: instruction fields.
- `D_stall_i`, in, 1: decode holds its current record.
- `D_bubble_i`, in, 1: flush the queue.
- `D_stat_o`, out, 3; `D_pc_o`, `D_valC_o`, `D_valP_o`, out, `PC_W`; `D_icode_o`, `D_ifun_o`, `D_rA_o`, `D_rB_o`, out, 4 each: head record.
- `D_valid_o`, out, 1: head record is real, not a bubble.
- `count_o`, out, `$clog2(DEPTH+1)`: number of occupied entries.

## Operation
- State: entry array[DEPTH], write pointer `wp`, read pointer `rp`, `count`.
- Both pointers wrap from DEPTH-1 to 0.
- `f_ready_o` = (count < DEPTH). It has no combinational dependency on `D_stall_i` or `D_bubble_i`.
- push = `f_valid_i` & `f_ready_o`.
- pop = ~`D_stall_i` & (count ≠ 0).
- Priority, highest first: reset, then bubble, then push/pop.
- Bubble:
  - count, wp and rp go to 0.
  - A push offered in the same cycle is discarded.
  - Bubble wins over stall.
- Simultaneous push and pop:
  - count is unchanged, both pointers advance.
  - This is legal at count = DEPTH only if ready was high, so it cannot occur when full.
- Push to full: impossible by construction. Pop from empty: no effect.
- Stall with count = 0: pushes still fill the queue.
- Head outputs:
  - When count ≠ 0: entry[rp], and `D_valid_o` = 1.
  - When count = 0: `D_stat_o` = `` `STAT_BUBBLE ``, `D_icode_o` = `` `INOP ``, `D_rA_o` = `D_rB_o` = `` `RNONE ``, all other fields 0, and `D_valid_o` = 0.
- Head outputs are decoded from registers only: no input-to-output combinational path.
- Reset (asserted at any time, including mid-operation):
  - count, wp and rp go to 0 immediately.
  - Outputs immediately show the empty/bubble record, except that `D_stat_o` is 0 during reset.
  - `f_ready_o` = 1 and `count_o` = 0.
  - Entry array contents are don't-care.

## Timing
- Fetch-to-decode latency is 1 cycle: a record pushed at edge N into an empty queue appears on `D_*` after edge N.
- A record is consumed at the first edge where `D_stall_i` = 0 while it is at the head.
- A full queue restores `f_ready_o` the cycle after a pop.
- Sustained throughput is one record per cycle when not stalled and DEPTH ≥ 2.
- Flush takes effect at the edge where `D_bubble_i` = 1; the following cycle shows the bubble record with `f_ready_o` = 1.

## Configuration
- `FDQ_HALT_HOLD_EN`:
  - A sticky `halted` flag sets at the edge where a record with `f_stat_i` ≠ `` `STAT_AOK `` is pushed.
  - While `halted` = 1, `f_ready_o` = 0, so nothing is fetched past a HLT, ADR or INS record.
  - `halted` clears on bubble or reset; bubble clears it even if that cycle also offers a non-AOK record, because the push is discarded.
  - Queued entries still drain normally.
- Without the macro: no `halted` state; status has no effect on acceptance.

## Test plan
- Reset, then 3 pushes with pc = 0x10, 0x1A and 0x24, no stall, DEPTH = 2 → `D_pc_o` shows 0x10, 0x1A, 0x24 on consecutive cycles with `D_valid_o` = 1, then `D_icode_o` = INOP and `D_valid_o` = 0.
- Hold `D_stall_i` = 1 and push continuously, DEPTH = 4 → `count_o` reaches 4 and `f_ready_o` = 0. Release the stall → the queue drains in order and `f_ready_o` = 1 one cycle after the first pop.
- Full queue with push and pop in the same cycle after release → count stays constant through wrap-around, and 10 records come out in order.
- `D_bubble_i` = 1 with count = 3, `D_stall_i` = 1 and `f_valid_i` = 1 → next cycle `count_o` = 0, `D_stat_o` = STAT_BUBBLE, and the offered record never appears.
- Assert `rst_n_i` = 0 mid-drain between clock edges → outputs go to the reset/bubble values without waiting for a clock edge, and `count_o` = 0.
- With `FDQ_HALT_HOLD_EN`: push an AOK record, then a record with stat = HLT → `f_ready_o` = 0 from the next cycle until `D_bubble_i`, while both records still drain in order. Without the macro: `f_ready_o` stays 1.
